fifo_ctrl_wifi: RTL and testbench
=================================

// Module: fifo_ctrl_wifi
// PURPOSE
//  Single-clock sequencer for the WiFi PHY FIFO RAM. Owns the write/read pointers, the
//  occupancy count and the status flags, and drives the RAM write/read strobes and addresses.
//  Sits between the PHY sample producer (wr side) and the consumer/AHB reader (rd side).
//  Depth need not be a power of two: pointers wrap explicitly at DEPTH_FIFO-1.
// PARAMETERS
//  ADDR_FIFO   8    RAM address width; must satisfy 2**ADDR_FIFO >= DEPTH_FIFO
//  DEPTH_FIFO  200  number of RAM entries in use
//  AFULL_LVL   192  almost_full asserted when count >= AFULL_LVL
//  AEMPTY_LVL  8    almost_empty asserted when count <= AEMPTY_LVL
// PORTS
//  HCLK          in   1            clock; RAM W_CLK and R_CLK are both tied to it
//  HRESETn       in   1            asynchronous reset, active low
//  wr_req        in   1            producer requests a write this cycle
//  rd_req        in   1            consumer requests a read this cycle
//  flush         in   1            synchronous clear of FIFO contents
//  clr_err       in   1            clears the sticky ovf/udf flags
//  ram_w_en      out  1            RAM W_CLK_en
//  ram_w_addr    out  ADDR_FIFO    RAM W_Addr (equals wr_ptr)
//  ram_r_en      out  1            RAM R_CLK_en
//  ram_r_addr    out  ADDR_FIFO    RAM R_Addr (equals rd_ptr)
//  rd_valid      out  1            RAM R_Data holds the accepted read data this cycle
//  count         out  ADDR_FIFO+1  current occupancy, 0..DEPTH_FIFO
//  full/empty    out  1 each       count==DEPTH_FIFO / count==0
//  almost_full   out  1            count >= AFULL_LVL
//  almost_empty  out  1            count <= AEMPTY_LVL
//  ovf/udf       out  1 each       sticky: write while full / read while empty
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0,
//   ovf=udf=0, rd_valid=0, ram_w_en=ram_r_en=0.
//  wr_acc = wr_req & ~full & ~flush; rd_acc = rd_req & ~empty & ~flush (combinational).
//  ram_w_en=wr_acc, ram_r_en=rd_acc; addresses are the registered pointers (no extra stage).
//  Full rejects writes even if a read is accepted in the same cycle (no pass-through).
//  Empty rejects reads even if a write is accepted in the same cycle (no bypass).
//  Pointer update: ptr <= (ptr==DEPTH_FIFO-1) ? 0 : ptr+1 on its accept; no other change.
//  count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
//  Flags are decoded from the registered count; they change the cycle after the accept edge.
//  Read latency 1: rd_valid <= rd_acc; data is valid on RAM R_Data while rd_valid=1.
//  flush has priority: pointers and count <= 0, rd_valid <= 0; same-cycle requests are
//   ignored; ovf/udf are not set by requests that are ignored because of flush.
//  ovf <= 1 on wr_req & full & ~flush; udf <= 1 on rd_req & empty & ~flush;
//   clr_err clears both; a same-cycle set wins over clr_err.
//  Reset asserted mid-operation returns all state to reset values immediately; RAM contents
//   are left as they are but are unreachable until rewritten.
// STRUCTURE
//  Shared header wifi_fifo_defs.vh: default ADDR_FIFO/DEPTH_FIFO/AFULL_LVL/AEMPTY_LVL.
//  Sub-module fifo_ptr_wrap (inc, clr -> ptr with wrap at DEPTH_FIFO-1), instantiated
//   twice (write and read pointers). Count, flag and error logic stay in the top module.
//  Elaboration check: error if 2**ADDR_FIFO < DEPTH_FIFO or AFULL_LVL > DEPTH_FIFO.
// TESTING
//  Reset, then idle 5 cycles -> count=0, empty=1, almost_empty=1, ram_w_en=ram_r_en=0.
//  200 writes then 1 more wr_req -> full=1 after write 200, ram_w_en=0 on write 201,
//   ovf=1; wr_ptr wraps to 0 after the write to address 199.
//  Fill to 100, drive wr_req=rd_req=1 for 300 cycles -> count holds 100, both pointers
//   wrap through 199->0, rd_valid=1 each cycle with data in write order.
//  Full, then wr_req=rd_req=1 -> read accepted, write rejected, count=199, ovf=1;
//   empty, then both requests -> write accepted, read rejected, count=1, udf=1.
//  Fill to 50, assert flush together with wr_req and rd_req -> count=0, empty=1, no strobes,
//   ovf/udf unchanged; the next write goes to address 0.
//  Assert HRESETn low mid-burst at count=120 -> all outputs return to reset values
//   asynchronously; resume writing -> first ram_w_addr=0.

Source files
------------

// File: rtl/fifo_ctrl_wifi_pkg.sv
// rtl/fifo_ctrl_wifi_pkg.sv - shared defaults and types for the WiFi PHY FIFO sequencer
package fifo_ctrl_wifi_pkg;

    // Default geometry shared by the top and the pointer sub-module.
    localparam int DEF_ADDR_FIFO  = 8;
    localparam int DEF_DEPTH_FIFO = 200;
    localparam int DEF_AFULL_LVL  = 192;
    localparam int DEF_AEMPTY_LVL = 8;

    // Per-cycle operation, {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_t'({wr_acc, rd_acc});
    endfunction

endpackage

// File: rtl/fifo_ctrl_wifi_ptr_wrap.sv
// rtl/fifo_ctrl_wifi_ptr_wrap.sv - RAM pointer that wraps explicitly at DEPTH-1
module fifo_ptr_wrap
    import fifo_ctrl_wifi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_FIFO,
    parameter int DEPTH  = DEF_DEPTH_FIFO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr
);

    // Depth need not be a power of two, so the wrap point is compared, not masked.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Pointer register: clear beats increment, increment wraps to zero after LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl_wifi.sv
// rtl/fifo_ctrl_wifi.sv - pointer, occupancy and status sequencer for the WiFi PHY FIFO RAM
module fifo_ctrl_wifi
    import fifo_ctrl_wifi_pkg::*;
#(
    parameter int ADDR_FIFO  = DEF_ADDR_FIFO,
    parameter int DEPTH_FIFO = DEF_DEPTH_FIFO,
    parameter int AFULL_LVL  = DEF_AFULL_LVL,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic                 ram_w_en,
    output logic [ADDR_FIFO-1:0] ram_w_addr,
    output logic                 ram_r_en,
    output logic [ADDR_FIFO-1:0] ram_r_addr,
    output logic                 rd_valid,
    output logic [ADDR_FIFO:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 ovf,
    output logic                 udf
);

    localparam int CW = ADDR_FIFO + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH_FIFO);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    generate
        if ((2 ** ADDR_FIFO) < DEPTH_FIFO) begin : g_bad_addr
            $error("fifo_ctrl_wifi: ADDR_FIFO too narrow for DEPTH_FIFO");
        end
        if (AFULL_LVL > DEPTH_FIFO) begin : g_bad_afull
            $error("fifo_ctrl_wifi: AFULL_LVL exceeds DEPTH_FIFO");
        end
    endgenerate

    logic            wr_acc;
    logic            rd_acc;
    fifo_op_t        op;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            rd_valid_q;
    logic            ovf_q;
    logic            udf_q;

    // Accepts: full blocks writes and empty blocks reads regardless of the other side.
    assign wr_acc = wr_req & ~full & ~flush;
    assign rd_acc = rd_req & ~empty & ~flush;
    assign op     = decode_op(wr_acc, rd_acc);

    assign ram_w_en = wr_acc;
    assign ram_r_en = rd_acc;

    fifo_ptr_wrap #(
        .ADDR_W (ADDR_FIFO),
        .DEPTH  (DEPTH_FIFO)
    ) u_wr_ptr (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .inc   (wr_acc),
        .clr   (flush),
        .ptr   (ram_w_addr)
    );

    fifo_ptr_wrap #(
        .ADDR_W (ADDR_FIFO),
        .DEPTH  (DEPTH_FIFO)
    ) u_rd_ptr (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .inc   (rd_acc),
        .clr   (flush),
        .ptr   (ram_r_addr)
    );

    // Next occupancy: simultaneous accepts cancel out.
    always_comb begin
        count_d = count_q;
        case (op)
            OP_WR:   count_d = count_q + CW'(1);
            OP_RD:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy and read-valid registers; flush empties the FIFO.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
        end
    end

    // Sticky error flags: a new violation wins over a same-cycle clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_req & full & ~flush) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd_req & empty & ~flush) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Status flags decode the registered count, so they lag the accept edge by one cycle.
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign rd_valid     = rd_valid_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_wifi.sv
// tb/tb_fifo_ctrl_wifi.sv - scoreboard bench for fifo_ctrl_wifi with an attached RAM model
module tb_fifo_ctrl_wifi;

    logic       HCLK;
    logic       HRESETn;
    logic       wr_req, rd_req, flush, clr_err;
    logic       ram_w_en, ram_r_en, rd_valid;
    logic [7:0] ram_w_addr, ram_r_addr;
    logic [8:0] count;
    logic       full, empty, almost_full, almost_empty, ovf, udf;

    logic [15:0] mem [0:255];
    logic [15:0] wdata;
    logic [15:0] rdata;

    int vectors = 0;
    int errs    = 0;
    int exp_reads = 0;
    int got_reads = 0;
    logic [15:0] exp_q[$];

    // model state
    int   mwp, mrp, mc;
    logic movf, mudf, mrv;
    int   seq;
    logic last_w_en, last_r_en;
    int   last_w_addr, last_r_addr;

    fifo_ctrl_wifi dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .flush        (flush),
        .clr_err      (clr_err),
        .ram_w_en     (ram_w_en),
        .ram_w_addr   (ram_w_addr),
        .ram_r_en     (ram_r_en),
        .ram_r_addr   (ram_r_addr),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // synchronous RAM attached to the controller strobes
    always @(posedge HCLK) begin
        if (ram_w_en) mem[ram_w_addr] <= wdata;
        if (ram_r_en) rdata <= mem[ram_r_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every rd_valid pops the oldest written word
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge HCLK);
            if (HRESETn && rd_valid) begin
                got_reads++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL rd_data: rd_valid with no pending word, data %0d", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        errs++;
                        $display("FAIL rd_data: got %0d expected %0d at %0t", rdata, e, $time);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        mwp = 0; mrp = 0; mc = 0; movf = 0; mudf = 0; mrv = 0;
        exp_q.delete();
    endtask

    task automatic check_state();
        chk("count", count, mc);
        chk("full", full, (mc == 200));
        chk("empty", empty, (mc == 0));
        chk("almost_full", almost_full, (mc >= 192));
        chk("almost_empty", almost_empty, (mc <= 8));
        chk("ovf", ovf, movf);
        chk("udf", udf, mudf);
        chk("rd_valid", rd_valid, mrv);
    endtask

    // one clock of stimulus; entered and left at posedge+1
    task automatic cyc(input logic w, input logic r, input logic f, input logic c);
        logic wa, ra, so, su;
        wr_req = w; rd_req = r; flush = f; clr_err = c;
        wdata = 16'(seq);
        wa = w && !f && (mc != 200);
        ra = r && !f && (mc != 0);
        so = w && !f && (mc == 200);
        su = r && !f && (mc == 0);
        #1;
        last_w_en = ram_w_en; last_r_en = ram_r_en;
        last_w_addr = ram_w_addr; last_r_addr = ram_r_addr;
        chk("ram_w_en", ram_w_en, wa);
        chk("ram_r_en", ram_r_en, ra);
        if (wa) begin
            chk("ram_w_addr", ram_w_addr, mwp);
            exp_q.push_back(wdata);
        end
        if (ra) begin
            chk("ram_r_addr", ram_r_addr, mrp);
            exp_reads++;
        end
        @(posedge HCLK);
        if (f) begin
            mwp = 0; mrp = 0; mc = 0;
            exp_q.delete();
        end else begin
            if (wa) mwp = (mwp == 199) ? 0 : mwp + 1;
            if (ra) mrp = (mrp == 199) ? 0 : mrp + 1;
            mc = mc + (wa ? 1 : 0) - (ra ? 1 : 0);
        end
        movf = so ? 1'b1 : (c ? 1'b0 : movf);
        mudf = su ? 1'b1 : (c ? 1'b0 : mudf);
        mrv  = ra;
        seq++;
        #1;
        check_state();
    endtask

    initial begin
        HRESETn = 1'b0;
        wr_req = 0; rd_req = 0; flush = 0; clr_err = 0;
        wdata = 0; seq = 1;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        HRESETn = 1'b1;

        // idle after reset
        repeat (5) cyc(0, 0, 0, 0);
        chk("idle_count", count, 0);
        chk("idle_empty", empty, 1);
        chk("idle_aempty", almost_empty, 1);
        chk("idle_w_en", last_w_en, 0);
        chk("idle_r_en", last_r_en, 0);

        // fill to full, then one extra write
        for (int i = 0; i < 200; i++) begin
            cyc(1, 0, 0, 0);
            chk("fill_addr", last_w_addr, i);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 200);
        chk("fill_afull", almost_full, 1);
        cyc(1, 0, 0, 0);
        chk("extra_w_en", last_w_en, 0);
        chk("extra_ovf", ovf, 1);
        cyc(0, 0, 0, 1);
        chk("clr_ovf", ovf, 0);

        // full with both requests: read only
        cyc(1, 1, 0, 0);
        chk("fb_r_en", last_r_en, 1);
        chk("fb_w_en", last_w_en, 0);
        chk("fb_count", count, 199);
        chk("fb_ovf", ovf, 1);

        // drain, then underflow
        repeat (199) cyc(0, 1, 0, 0);
        chk("drain_empty", empty, 1);
        cyc(0, 1, 0, 0);
        chk("drain_udf", udf, 1);
        cyc(0, 0, 0, 1);
        chk("clr_udf", udf, 0);
        chk("clr_ovf2", ovf, 0);

        // empty with both requests: write only, write pointer wrapped to 0
        cyc(1, 1, 0, 0);
        chk("eb_w_en", last_w_en, 1);
        chk("eb_w_addr", last_w_addr, 0);
        chk("eb_r_en", last_r_en, 0);
        chk("eb_count", count, 1);
        chk("eb_udf", udf, 1);

        // steady streaming at 100
        repeat (99) cyc(1, 0, 0, 0);
        chk("steady_start", count, 100);
        repeat (300) cyc(1, 1, 0, 0);
        chk("steady_count", count, 100);
        chk("steady_rvalid", rd_valid, 1);

        // flush behaviour
        cyc(0, 0, 1, 0);
        chk("flush_count", count, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        chk("udf_set", udf, 1);
        cyc(0, 1, 0, 1);
        chk("udf_set_wins", udf, 1);
        repeat (50) cyc(1, 0, 0, 0);
        chk("pre_flush", count, 50);
        cyc(1, 1, 1, 0);
        chk("fl_w_en", last_w_en, 0);
        chk("fl_r_en", last_r_en, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_udf", udf, 1);
        chk("fl_ovf", ovf, 0);
        cyc(1, 0, 0, 0);
        chk("fl_next_addr", last_w_addr, 0);

        // asynchronous reset mid-burst
        cyc(0, 0, 1, 0);
        repeat (120) cyc(1, 0, 0, 0);
        chk("pre_rst_count", count, 120);
        wr_req = 1; wdata = 16'(seq);
        #2;
        HRESETn = 1'b0;
        wr_req = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_aempty", almost_empty, 1);
        chk("arst_full", full, 0);
        chk("arst_afull", almost_full, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_udf", udf, 0);
        chk("arst_rvalid", rd_valid, 0);
        chk("arst_w_en", ram_w_en, 0);
        chk("arst_r_en", ram_r_en, 0);
        chk("arst_w_addr", ram_w_addr, 0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        wr_req = 1;
        #1;
        chk("resume_w_en", ram_w_en, 1);
        chk("resume_w_addr", ram_w_addr, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        chk("read_total", got_reads, exp_reads);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
